// File: rtl/hdlc_axis_upload_mux.sv
// Multi-channel HDLC upload multiplexer: forwards AXI-Stream beats from CH_NUM receive
// channels onto one master stream under a software beat budget, round-robin at packet edges.
module hdlc_axis_upload_mux #(
  parameter int CH_NUM     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int ID_WIDTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         upload_req,
  input  logic [LEN_WIDTH-1:0]         upload_length,
  output logic                         upload_busy,
  output logic                         upload_done,
  input  logic                         skip_arb,
  input  logic [CH_NUM-1:0]            s_axis_tvalid,
  output logic [CH_NUM-1:0]            s_axis_tready,
  input  logic [CH_NUM*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CH_NUM-1:0]            s_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic [ID_WIDTH-1:0]          m_axis_tid
);

  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef logic [CH_W-1:0] ch_t;
  typedef enum logic [1:0] {IDLE, ARB, XFER, DONE} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] remain;
  ch_t                  grant;
  ch_t                  last_ch;
  logic                 lock;
  logic                 boundary;
  logic                 busy_q;
  logic                 done_q;

  ch_t                  ptr;
  ch_t                  rr_pick;
  ch_t                  idx;
  logic                 rr_found;
  logic                 xfer;
  logic                 g_valid;
  logic                 g_last;
  logic                 last_beat;
  logic                 hs;
  logic [DATA_WIDTH-1:0] data_arr [CH_NUM];

  for (genvar i = 0; i < CH_NUM; i++) begin : g_unpack
    assign data_arr[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign ptr = (last_ch == ch_t'(CH_NUM - 1)) ? '0 : last_ch + 1'b1;

  // First valid channel at or after ptr, wrapping at CH_NUM.
  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path can infer a latch.
    rr_pick  = ptr;
    rr_found = 1'b0;
    idx      = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = ch_t'((int'(ptr) + k) % CH_NUM);
      if (!rr_found && s_axis_tvalid[idx]) begin
        rr_pick  = idx;
        rr_found = 1'b1;
      end
    end
  end

  assign xfer      = (state == XFER);
  assign g_valid   = s_axis_tvalid[grant];
  assign g_last    = s_axis_tlast[grant];
  assign last_beat = (remain == LEN_WIDTH'(1));
  assign hs        = xfer && g_valid && m_axis_tready;

  assign m_axis_tvalid = xfer && g_valid;
  assign m_axis_tdata  = xfer ? data_arr[grant] : '0;
  assign m_axis_tlast  = xfer && (g_last || last_beat);
  assign m_axis_tid    = ID_WIDTH'(grant);
  assign upload_busy   = busy_q;
  assign upload_done   = done_q;

  always_comb begin
    s_axis_tready = '0;
    if (xfer) s_axis_tready[grant] = m_axis_tready;
  end

  // NOTE: non-blocking assignments so every register below samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      remain   <= '0;
      grant    <= '0;
      last_ch  <= ch_t'(CH_NUM - 1);
      lock     <= 1'b0;
      boundary <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (upload_req) begin
            busy_q <= 1'b1;
            remain <= upload_length;
            if (upload_length == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= ARB;
            end
          end
        end
        ARB: begin
          boundary <= 1'b0;
          if (lock) begin
            grant <= last_ch;
            state <= XFER;
          end else if (rr_found) begin
            grant <= rr_pick;
            state <= XFER;
          end
        end
        XFER: begin
          if (hs) begin
            remain <= remain - 1'b1;
            if (last_beat) begin
              // A budget that ends mid-packet pins the next upload to this channel.
              lock    <= !g_last;
              last_ch <= grant;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end else if (g_last) begin
              lock    <= 1'b0;
              last_ch <= grant;
              if (skip_arb) boundary <= 1'b1;
              else          state    <= ARB;
            end else begin
              boundary <= 1'b0;
            end
          end else if (boundary && !g_valid) begin
            // Held channel ran dry after its packet: fall back to arbitration.
            boundary <= 1'b0;
            state    <= ARB;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
